// File: rtl/sync_counter_pkg.sv
// rtl/sync_counter_pkg.sv - shared width, terminal value and count type for sync_counter3
`timescale 1ns/100ps
package sync_counter_pkg;
    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = 3'd7;
    typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/sync_tff.sv
// rtl/sync_tff.sv - T flip-flop with asynchronous active-high clear that loads init
`timescale 1ns/100ps
module sync_tff (
    input  logic clock,
    input  logic clear,
    input  logic t,
    input  logic init,
    output logic q
);
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            q <= init;
        end else if (t) begin
            q <= ~q;
        end
    end
endmodule

// File: rtl/sync_counter3.sv
// rtl/sync_counter3.sv - 3-bit synchronous up-counter built from T flip-flops
// Optional terminal-count output tc is built when SYNC_COUNTER3_TC_EN is defined.
`timescale 1ns/100ps
module sync_counter3
    import sync_counter_pkg::*;
#(
    parameter cnt_t RESET_VALUE = 3'b000
) (
    input  logic clock,
    input  logic clear,
    input  logic enable,
    output logic Y0,
    output logic Y1,
    output logic Y2
`ifdef SYNC_COUNTER3_TC_EN
    ,
    output logic tc
`endif
);
    cnt_t q;
    cnt_t t;

    // Each bit toggles only when enable and every lower bit are set.
    always_comb begin
        t    = '0;
        t[0] = enable;
        t[1] = enable & q[0];
        t[2] = enable & q[0] & q[1];
    end

    for (genvar i = 0; i < CNT_W; i++) begin : g_bit
        sync_tff u_tff (
            .clock (clock),
            .clear (clear),
            .t     (t[i]),
            .init  (RESET_VALUE[i]),
            .q     (q[i])
        );
    end

    assign Y0 = q[0];
    assign Y1 = q[1];
    assign Y2 = q[2];

`ifdef SYNC_COUNTER3_TC_EN
    // Gated by clear so a RESET_VALUE of 7 cannot flag a wrap during reset.
    assign tc = enable & ~clear & (q == CNT_MAX);
`else
`endif
endmodule

// File: tb/tb_sync_counter3.sv
// tb/tb_sync_counter3.sv - self-checking bench for sync_counter3 (default and RESET_VALUE=4)
`timescale 1ns/100ps
module tb_sync_counter3;
    logic clock;
    logic clear;
    logic enable;
    logic a_y0, a_y1, a_y2;
    logic b_y0, b_y1, b_y2;
`ifdef SYNC_COUNTER3_TC_EN
    logic a_tc, b_tc;
`endif

    int errors = 0;
    int checks = 0;
    int m_a;
    int m_b;

    sync_counter3 #(.RESET_VALUE(3'd0)) dut_a (
        .clock  (clock),
        .clear  (clear),
        .enable (enable),
        .Y0     (a_y0),
        .Y1     (a_y1),
        .Y2     (a_y2)
`ifdef SYNC_COUNTER3_TC_EN
        ,
        .tc     (a_tc)
`endif
    );

    sync_counter3 #(.RESET_VALUE(3'd4)) dut_b (
        .clock  (clock),
        .clear  (clear),
        .enable (enable),
        .Y0     (b_y0),
        .Y1     (b_y1),
        .Y2     (b_y2)
`ifdef SYNC_COUNTER3_TC_EN
        ,
        .tc     (b_tc)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #1 clock = ~clock;
    end

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_both(input string tag);
        logic [2:0] ea, eb;
        ea = 3'(m_a);
        eb = 3'(m_b);
        check({tag, "_a"}, {a_y2, a_y1, a_y0}, ea);
        check({tag, "_b"}, {b_y2, b_y1, b_y0}, eb);
    endtask

    task automatic check_tc(input string tag);
`ifdef SYNC_COUNTER3_TC_EN
        logic [2:0] ea, eb;
        ea = {2'b00, (enable && !clear && m_a == 7)};
        eb = {2'b00, (enable && !clear && m_b == 7)};
        check({tag, "_tc_a"}, {2'b00, a_tc}, ea);
        check({tag, "_tc_b"}, {2'b00, b_tc}, eb);
`endif
    endtask

    // One rising edge: the model advances by the counting rules, then outputs are sampled mid-cycle.
    task automatic tick(input string tag);
        @(posedge clock);
        if (clear) begin
            m_a = 0;
            m_b = 4;
        end else if (enable) begin
            m_a = (m_a + 1) % 8;
            m_b = (m_b + 1) % 8;
        end
        #0.5;
        check_both(tag);
    endtask

    initial begin
        clear  = 1'b1;
        enable = 1'b0;
        m_a    = 0;
        m_b    = 4;
        #0.5;
        check_both("reset_no_edge");
        check_tc("reset");

        clear  = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 15; i++) tick("seq");
        check("seq_end", {a_y2, a_y1, a_y0}, 3'd7);

        for (int i = 0; i < 6; i++) tick("to5");
        enable = 1'b0;
        for (int i = 0; i < 3; i++) tick("hold");
        check("hold_at5", {a_y2, a_y1, a_y0}, 3'd5);
        enable = 1'b1;
        tick("resume");
        check("resume_6", {a_y2, a_y1, a_y0}, 3'd6);
        tick("to7");
        check_tc("pre_wrap");
        tick("wrap");
        check("wrap_0", {a_y2, a_y1, a_y0}, 3'd0);

        for (int i = 0; i < 6; i++) tick("to6");
        clear = 1'b1;
        m_a   = 0;
        m_b   = 4;
        #0.2;
        check_both("async_clear");
        check_tc("async_clear");
        #0.1;
        clear = 1'b0;
        tick("after_clear");
        check("after_clear_1", {a_y2, a_y1, a_y0}, 3'd1);
        check("after_clear_5", {b_y2, b_y1, b_y0}, 3'd5);

        clear  = 1'b1;
        enable = 1'b1;
        tick("prio1");
        tick("prio2");
        check("prio_rv4", {b_y2, b_y1, b_y0}, 3'd4);
        clear = 1'b0;

        for (int i = 0; i < 60; i++) begin
            enable = 1'($urandom_range(0, 3) != 0);
            clear  = ($urandom_range(0, 11) == 0);
            if (clear) begin
                m_a = 0;
                m_b = 4;
                #0.1;
                check_both("rand_async");
            end
            check_tc("rand");
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000;
        errors++;
        $display("FAIL timeout: observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
